sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/slc3_mem_pkg.sv | 41 ++++
 rtl/sram_byte_array.sv | 32 +++
 rtl/sram_responder.sv | 132 +++++++++++++
 tb/tb_sram_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared states, latency bounds and command decode for the SRAM responder
package slc3_mem_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_DRIVE = 2'd2,
    ST_WR       = 2'd3
  } state_e;

  // Bus command seen in one cycle
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;
  // Wide enough to hold RD_LAT_MAX-1
  localparam int CNT_W      = 3;

  // Active-low strobes; WE low wins over OE low
  function automatic cmd_e decode_cmd(input logic ce_n, input logic oe_n, input logic we_n);
    cmd_e v_cmd;
    v_cmd = CMD_IDLE;
    if (!ce_n && !we_n) begin
      v_cmd = CMD_WRITE;
    end else if (!ce_n && !oe_n) begin
      v_cmd = CMD_READ;
    end
    return v_cmd;
  endfunction

  // All three strobes low at once is an illegal command
  function automatic logic is_conflict(input logic ce_n, input logic oe_n, input logic we_n);
    return !ce_n && !oe_n && !we_n;
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// rtl/sram_byte_array.sv - 16-bit word array with per-byte write enables and async read
module sram_byte_array #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_be_hi,
  input  logic              i_be_lo,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] r_mem_hi [DEPTH];
  logic [7:0] r_mem_lo [DEPTH];

  // Byte-lane writes; lanes are independent so a partial write keeps the other byte
  always_ff @(posedge i_clk) begin
    if (i_we && i_be_hi) begin
      r_mem_hi[i_waddr] <= i_wdata[15:8];
    end
    if (i_we && i_be_lo) begin
      r_mem_lo[i_waddr] <= i_wdata[7:0];
    end
  end

  assign o_rdata = {r_mem_hi[i_raddr], r_mem_lo[i_raddr]};

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - async-SRAM style bus responder with programmable read latency
module sram_responder
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  input  logic [19:0] ADDR,
  inout  wire  [15:0] Data,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        conflict
);

  // Out-of-range latencies are clamped rather than producing a broken counter
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_rd_count;
  logic [15:0]       r_wr_count;
  logic              r_conflict;

  cmd_e              w_cmd;
  logic              w_read;
  logic              w_write;
  logic              w_conflict;
  logic [ADDR_W-1:0] w_addr;
  logic              w_same;
  logic              w_drive;
  logic [15:0]       w_rdata;
  logic              w_unused_addr;

  assign w_cmd       = decode_cmd(CE, OE, WE);
  assign w_read      = (w_cmd == CMD_READ);
  assign w_write     = (w_cmd == CMD_WRITE);
  assign w_conflict  = is_conflict(CE, OE, WE);
  // Upper address bits alias onto the implemented depth
  assign w_addr      = ADDR[ADDR_W-1:0];
  assign w_unused_addr = ^ADDR;
  assign w_same      = (w_addr == r_addr);

  sram_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (Clk),
    .i_we    (w_write && !Reset),
    .i_be_hi (!UB),
    .i_be_lo (!LB),
    .i_waddr (w_addr),
    .i_wdata (Data),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  // Drive only while a read of the latched address is still on the bus; WE low never drives
  assign w_drive    = (r_state == ST_RD_DRIVE) && w_read && w_same;
  assign Data[15:8] = (w_drive && !UB) ? w_rdata[15:8] : 8'hzz;
  assign Data[7:0]  = (w_drive && !LB) ? w_rdata[7:0]  : 8'hzz;

  // Control FSM, counters and sticky conflict flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_rd_count <= '0;
      r_wr_count <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_conflict) begin
        r_conflict <= 1'b1;
      end
      if (w_write) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      case (r_state)
        ST_IDLE, ST_RD_WAIT, ST_RD_DRIVE: begin
          if (w_write) begin
            r_state <= ST_WR;
            r_cnt   <= '0;
          end else if (!w_read) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_state == ST_IDLE || !w_same) begin
            // New read or address change: latch and (re)start the latency count
            r_addr <= w_addr;
            if (LAT == 1) begin
              r_state    <= ST_RD_DRIVE;
              r_cnt      <= '0;
              r_rd_count <= r_rd_count + 16'd1;
            end else begin
              r_state <= ST_RD_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end else if (r_state == ST_RD_WAIT) begin
            if (r_cnt <= CNT_W'(1)) begin
              r_state    <= ST_RD_DRIVE;
              r_cnt      <= '0;
              r_rd_count <= r_rd_count + 16'd1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        ST_WR: begin
          if (!w_write) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder
module tb_sram_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CE, OE, WE, UB, LB;
  logic [19:0] ADDR;
  wire  [15:0] Data;
  logic [15:0] rd_count, wr_count;
  logic        conflict;

  logic        drv_en;
  logic [15:0] drv_val;

  // Undriven bus lanes float high through the pullups, so a Z byte reads 8'hFF
  assign Data = drv_en ? drv_val : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (Data[i]);
  end

  sram_responder dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .CE       (CE),
    .OE       (OE),
    .WE       (WE),
    .UB       (UB),
    .LB       (LB),
    .ADDR     (ADDR),
    .Data     (Data),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .conflict (conflict)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [15:0] rd;
    logic [15:0] wr;
    logic        conf;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: one expectation per cycle, compared mid-cycle against live outputs
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (Data !== e.data || rd_count !== e.rd || wr_count !== e.wr || conflict !== e.conf) begin
        n_fail++;
        $display("FAIL %s: got data=%h rd=%0d wr=%0d conf=%b, need data=%h rd=%0d wr=%0d conf=%b",
                 e.name, Data, rd_count, wr_count, conflict, e.data, e.rd, e.wr, e.conf);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input string name, input logic [15:0] data, input logic [15:0] rd,
                      input logic [15:0] wr, input logic conf);
    exp_t e;
    e.name = name; e.data = data; e.rd = rd; e.wr = wr; e.conf = conf;
    q.push_back(e);
  endtask

  task automatic set_idle();
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0; drv_en = 1'b0;
  endtask

  task automatic set_read(input logic [19:0] a, input logic ub, input logic lb);
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = ub; LB = lb; ADDR = a; drv_en = 1'b0;
  endtask

  task automatic set_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb; ADDR = a; drv_en = 1'b1; drv_val = d;
  endtask

  // One write cycle followed by an idle cycle that lets the FSM leave WR
  task automatic do_write(input string name, input logic [19:0] a, input logic [15:0] d,
                          input logic ub, input logic lb, input logic [15:0] rd,
                          input logic [15:0] wr_after, input logic conf);
    set_write(a, d, ub, lb);
    step();
    set_idle();
    push(name, 16'hFFFF, rd, wr_after, conf);
    step();
  endtask

  // RD_LAT=2: Z in the command cycle and the wait cycle, then data for two cycles
  task automatic read_chk(input string name, input logic [19:0] a, input logic ub, input logic lb,
                          input logic [15:0] exp_d, input logic [15:0] rd_before,
                          input logic [15:0] wr, input logic conf);
    set_read(a, ub, lb);
    push({name, "_c0z"}, 16'hFFFF, rd_before, wr, conf);
    step();
    push({name, "_c1z"}, 16'hFFFF, rd_before, wr, conf);
    step();
    push({name, "_d0"}, exp_d, rd_before + 16'd1, wr, conf);
    step();
    push({name, "_d1"}, exp_d, rd_before + 16'd1, wr, conf);
    step();
    set_idle();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ADDR = '0; drv_val = '0;
    set_idle();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
    push("reset", 16'hFFFF, 16'd0, 16'd0, 1'b0);
    step();

    do_write("wr_beef", 20'h00005, 16'hBEEF, 1'b0, 1'b0, 16'd0, 16'd1, 1'b0);
    read_chk("rd_beef", 20'h00005, 1'b0, 1'b0, 16'hBEEF, 16'd0, 16'd1, 1'b0);

    do_write("wr_1234", 20'h00010, 16'h1234, 1'b0, 1'b0, 16'd1, 16'd2, 1'b0);
    do_write("wr_ab_hi", 20'h00010, 16'hAB00, 1'b0, 1'b1, 16'd1, 16'd3, 1'b0);
    read_chk("rd_ab34", 20'h00010, 1'b0, 1'b0, 16'hAB34, 16'd1, 16'd3, 1'b0);
    read_chk("rd_lo_only", 20'h00010, 1'b1, 1'b0, 16'hFF34, 16'd2, 16'd3, 1'b0);

    do_write("wr_alias", 20'h00400, 16'h5555, 1'b0, 1'b0, 16'd3, 16'd4, 1'b0);
    read_chk("rd_alias", 20'h00000, 1'b0, 1'b0, 16'h5555, 16'd3, 16'd4, 1'b0);

    // Address change in RD_WAIT restarts the latency
    set_read(20'h00005, 1'b0, 1'b0);
    push("chg_c0z", 16'hFFFF, 16'd4, 16'd4, 1'b0);
    step();
    set_read(20'h00010, 1'b0, 1'b0);
    push("chg_c1z", 16'hFFFF, 16'd4, 16'd4, 1'b0);
    step();
    push("chg_restart_z", 16'hFFFF, 16'd4, 16'd4, 1'b0);
    step();
    push("chg_data", 16'hAB34, 16'd5, 16'd4, 1'b0);
    step();
    set_idle();
    step();

    // All strobes low: treated as a write and flags a conflict
    CE = 1'b0; OE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; ADDR = 20'h00030;
    drv_en = 1'b1; drv_val = 16'h0C0C;
    step();
    set_idle();
    push("conflict_set", 16'hFFFF, 16'd5, 16'd5, 1'b1);
    step();
    read_chk("rd_conflict_wr", 20'h00030, 1'b0, 1'b0, 16'h0C0C, 16'd5, 16'd5, 1'b1);

    // A write coinciding with Reset must leave the array alone
    Reset = 1'b1;
    set_write(20'h00005, 16'h0F0F, 1'b0, 1'b0);
    step();
    Reset = 1'b0;
    set_idle();
    push("rst_clears", 16'hFFFF, 16'd0, 16'd0, 1'b0);
    step();
    read_chk("rd_after_rst_wr", 20'h00005, 1'b0, 1'b0, 16'hBEEF, 16'd0, 16'd0, 1'b0);

    // Reset while driving: bus releases, counters clear, contents survive
    set_read(20'h00010, 1'b0, 1'b0);
    push("rdr_c0z", 16'hFFFF, 16'd1, 16'd0, 1'b0);
    step();
    push("rdr_c1z", 16'hFFFF, 16'd1, 16'd0, 1'b0);
    step();
    push("rdr_drive", 16'hAB34, 16'd2, 16'd0, 1'b0);
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    push("rdr_rst_z", 16'hFFFF, 16'd0, 16'd0, 1'b0);
    step();
    push("rdr_rst_c1z", 16'hFFFF, 16'd0, 16'd0, 1'b0);
    step();
    push("rdr_preserved", 16'hAB34, 16'd1, 16'd0, 1'b0);
    step();
    set_idle();
    step();
    step();

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
